time_set_controller: RTL and testbench

Button-driven time-setting front end for the 24-hour clock. It debounces three push-buttons and lets the user step through hours, minutes and seconds, starting from the clock's live time. It edits each field in BCD with wrap-around. On completion it drives the clock's `Time_in` bus and issues a one-cycle `Set_time` load strobe. It is the writer side of the clock's time-load interface.

---
 rtl/time_set_controller_if.sv | 25 ++
 rtl/time_set_controller.sv | 143 ++++++++++++++
 tb/tb_time_set_controller.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/time_set_controller_if.sv
// Time-load bus between the time-setting front end (master) and the 24-hour clock (slave).
// BCD layout on both time buses: {Ht,Ho,Mt,Mo,St,So}, Ht at [23:20].
interface time_set_controller_if;
    logic [23:0] Time_now;
    logic [23:0] Time_in;
    logic        Set_time;
    logic        Editing;
    logic [1:0]  Field_sel;

    modport master (
        input  Time_now,
        output Time_in,
        output Set_time,
        output Editing,
        output Field_sel
    );

    modport slave (
        output Time_now,
        input  Time_in,
        input  Set_time,
        input  Editing,
        input  Field_sel
    );
endinterface

// File: rtl/time_set_controller.sv
// Button-driven time setter: debounces Mode/Inc/Dec, edits a BCD shadow of the live time
// field by field, then loads it into the clock with a one-cycle Set_time strobe.
module time_set_controller #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic                          CLK,
    input  logic                          Reset,
    input  logic                          Mode_btn,
    input  logic                          Inc_btn,
    input  logic                          Dec_btn,
    time_set_controller_if.master         tbus
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);

    typedef enum logic [2:0] {
        IDLE,
        EDIT_HR,
        EDIT_MIN,
        EDIT_SEC,
        COMMIT
    } state_t;

    // Bit 0 = Mode, bit 1 = Inc, bit 2 = Dec.
    logic [2:0] raw;
    logic [2:0] sync1, sync2, deb, deb_d;
    logic [7:0] cnt [3];
    logic [2:0] press;

    state_t      state_q, state_d;
    logic [23:0] shadow_q, shadow_d;

    logic mode_p, inc_p, dec_p, step;

    assign raw = {Dec_btn, Inc_btn, Mode_btn};

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int unsigned b = 0; b < 3; b++) cnt[b] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            for (int unsigned b = 0; b < 3; b++) begin
                if (sync2[b] == deb[b]) begin
                    cnt[b] <= '0;
                end else if (cnt[b] == CNT_LAST) begin
                    deb[b] <= sync2[b];
                    cnt[b] <= '0;
                end else begin
                    cnt[b] <= cnt[b] + 8'd1;
                end
            end
        end
    end

    assign press  = deb & ~deb_d;
    assign mode_p = press[0];
    assign inc_p  = press[1];
    assign dec_p  = press[2];
    // Inc and Dec landing together cancel out.
    assign step   = inc_p ^ dec_p;

    // Wrap-around BCD step; a field holding a non-decimal or out-of-range value resyncs to
    // 00 on Inc and to the maximum on Dec.
    function automatic logic [7:0] adjust(input logic [7:0] f, input logic [7:0] max_v,
                                          input logic [7:0] max_bcd, input logic up);
        logic [3:0] t, o;
        logic [7:0] v;
        logic       bad;
        t   = f[7:4];
        o   = f[3:0];
        v   = {4'd0, t} * 8'd10 + {4'd0, o};
        bad = (o > 4'd9) || (v > max_v);
        if (up) begin
            if (bad || v == max_v) adjust = 8'h00;
            else if (o == 4'd9)    adjust = {t + 4'd1, 4'd0};
            else                   adjust = {t, o + 4'd1};
        end else begin
            if (bad || v == 8'd0)  adjust = max_bcd;
            else if (o == 4'd0)    adjust = {t - 4'd1, 4'd9};
            else                   adjust = {t, o - 4'd1};
        end
    endfunction

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        unique case (state_q)
            IDLE: begin
                if (mode_p) begin
                    state_d  = EDIT_HR;
                    shadow_d = tbus.Time_now;
                end
            end
            EDIT_HR: begin
                if (mode_p)    state_d = EDIT_MIN;
                else if (step) shadow_d[23:16] = adjust(shadow_q[23:16], 8'd23, 8'h23, inc_p);
            end
            EDIT_MIN: begin
                if (mode_p)    state_d = EDIT_SEC;
                else if (step) shadow_d[15:8] = adjust(shadow_q[15:8], 8'd59, 8'h59, inc_p);
            end
            EDIT_SEC: begin
                if (mode_p)    state_d = COMMIT;
                else if (step) shadow_d[7:0] = adjust(shadow_q[7:0], 8'd59, 8'h59, inc_p);
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode straight from registered state, so reset clears them asynchronously.
    always_comb begin
        tbus.Editing   = 1'b0;
        tbus.Field_sel = 2'b00;
        tbus.Set_time  = 1'b0;
        unique case (state_q)
            EDIT_HR:  begin tbus.Editing = 1'b1; tbus.Field_sel = 2'b01; end
            EDIT_MIN: begin tbus.Editing = 1'b1; tbus.Field_sel = 2'b10; end
            EDIT_SEC: begin tbus.Editing = 1'b1; tbus.Field_sel = 2'b11; end
            COMMIT:   tbus.Set_time = 1'b1;
            default:  ;
        endcase
    end

    assign tbus.Time_in = shadow_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Self-checking bench for time_set_controller: directed scenarios plus randomized button
// sequences scored against a decimal-arithmetic model of the edit rules.
module tb_time_set_controller;

    localparam int DEB = 4;

    logic CLK = 1'b0;
    logic Reset = 1'b1;
    logic Mode_btn = 1'b0;
    logic Inc_btn = 1'b0;
    logic Dec_btn = 1'b0;

    time_set_controller_if bus ();

    time_set_controller #(.DEBOUNCE(DEB)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Mode_btn (Mode_btn),
        .Inc_btn  (Inc_btn),
        .Dec_btn  (Dec_btn),
        .tbus     (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: selected field (0 none, 1 hr, 2 min, 3 sec) and shadow time.
    int          m_fld = 0;
    logic [23:0] m_sh  = '0;
    int          exp_pulses;

    int          pulses;
    logic [23:0] tin_prev, tin_pulse, tin_next;

    function automatic logic [7:0] ref_step(input logic [7:0] f, input int max, input bit up);
        int t, o, v;
        bit bad;
        t   = int'(f[7:4]);
        o   = int'(f[3:0]);
        v   = t * 10 + o;
        bad = (o > 9) || (v > max);
        if (up) v = (bad || v == max) ? 0 : v + 1;
        else    v = (bad || v == 0) ? max : v - 1;
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_apply(input bit m, input bit i, input bit d);
        int lo, max;
        exp_pulses = 0;
        if (m) begin
            case (m_fld)
                0: begin m_sh = bus.Time_now; m_fld = 1; end
                1: m_fld = 2;
                2: m_fld = 3;
                default: begin exp_pulses = 1; m_fld = 0; end
            endcase
        end else if (m_fld != 0 && (i ^ d)) begin
            lo  = (3 - m_fld) * 8;
            max = (m_fld == 1) ? 23 : 59;
            m_sh[lo +: 8] = ref_step(m_sh[lo +: 8], max, i);
        end
    endtask

    // Drive a press of the given buttons for `hold` raw cycles, then let the debouncer settle.
    // Records Set_time pulses and Time_in around the pulse.
    task automatic press(input bit m, input bit i, input bit d, input int hold);
        bit          scramble, want_next;
        logic [23:0] prev, cur;
        scramble  = (m_fld != 0);
        if (hold >= DEB + 3) model_apply(m, i, d);
        else exp_pulses = 0;
        pulses    = 0;
        want_next = 0;
        prev      = bus.Time_in;
        @(negedge CLK);
        Mode_btn = m; Inc_btn = i; Dec_btn = d;
        for (int c = 0; c < hold + DEB + 6; c++) begin
            if (c == hold) begin Mode_btn = 0; Inc_btn = 0; Dec_btn = 0; end
            if (scramble) bus.Time_now = 24'($urandom);
            @(negedge CLK);
            cur = bus.Time_in;
            if (want_next) begin tin_next = cur; want_next = 0; end
            if (bus.Set_time) begin
                pulses++;
                tin_pulse = cur;
                tin_prev  = prev;
                want_next = 1;
            end
            prev = cur;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        Reset = 1; Mode_btn = 0; Inc_btn = 0; Dec_btn = 0;
        repeat (3) @(negedge CLK);
        Reset = 0;
        m_fld = 0;
        m_sh  = '0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bus.Time_in !== 24'h0) begin errors++; $display("FAIL reset_time_in got %h want 000000", bus.Time_in); end
        checks++; if (bus.Set_time !== 1'b0) begin errors++; $display("FAIL reset_set_time got %b want 0", bus.Set_time); end
        checks++; if (bus.Editing !== 1'b0) begin errors++; $display("FAIL reset_editing got %b want 0", bus.Editing); end
        checks++; if (bus.Field_sel !== 2'b00) begin errors++; $display("FAIL reset_field_sel got %b want 00", bus.Field_sel); end
        do_reset();
    endtask

    task automatic test_mode_entry();
        bus.Time_now = 24'h134509;
        @(negedge CLK);
        Mode_btn = 1;
        repeat (DEB + 2) @(posedge CLK);
        #1;
        checks++; if (bus.Editing !== 1'b0) begin errors++; $display("FAIL entry_early got editing %b want 0", bus.Editing); end
        @(posedge CLK);
        #1;
        checks++; if (bus.Editing !== 1'b1) begin errors++; $display("FAIL entry_editing got %b want 1", bus.Editing); end
        checks++; if (bus.Field_sel !== 2'b01) begin errors++; $display("FAIL entry_field_sel got %b want 01", bus.Field_sel); end
        checks++; if (bus.Time_in !== 24'h134509) begin errors++; $display("FAIL entry_time_in got %h want 134509", bus.Time_in); end
        m_fld = 1;
        m_sh  = 24'h134509;
        repeat (10 - (DEB + 3)) @(posedge CLK);
        @(negedge CLK);
        Mode_btn = 0;
        bus.Time_now = 24'h000000;
        repeat (DEB + 6) @(posedge CLK);
        #1;
        checks++; if (bus.Time_in !== 24'h134509) begin errors++; $display("FAIL entry_hold got %h want 134509", bus.Time_in); end
    endtask

    task automatic test_hours();
        do_reset();
        bus.Time_now = 24'h231547;
        press(1, 0, 0, 10);
        press(0, 1, 0, 10);
        checks++; if (bus.Time_in !== 24'h001547) begin errors++; $display("FAIL hr_inc_wrap got %h want 001547", bus.Time_in); end
        press(0, 0, 1, 10);
        checks++; if (bus.Time_in !== 24'h231547) begin errors++; $display("FAIL hr_dec_wrap got %h want 231547", bus.Time_in); end
        press(0, 0, 1, 10);
        checks++; if (bus.Time_in !== 24'h221547) begin errors++; $display("FAIL hr_dec got %h want 221547", bus.Time_in); end
        do_reset();
        bus.Time_now = 24'h094200;
        press(1, 0, 0, 10);
        press(0, 1, 0, 10);
        checks++; if (bus.Time_in !== 24'h104200) begin errors++; $display("FAIL hr_inc_carry got %h want 104200", bus.Time_in); end
    endtask

    task automatic test_minutes();
        do_reset();
        bus.Time_now = 24'h125900;
        press(1, 0, 0, 10);
        press(1, 0, 0, 10);
        press(0, 1, 0, 10);
        checks++; if (bus.Time_in !== 24'h120000) begin errors++; $display("FAIL min_inc_wrap got %h want 120000", bus.Time_in); end
        press(0, 0, 1, 10);
        checks++; if (bus.Time_in !== 24'h125900) begin errors++; $display("FAIL min_dec_wrap got %h want 125900", bus.Time_in); end
        do_reset();
        bus.Time_now = 24'h127A33;
        press(1, 0, 0, 10);
        press(1, 0, 0, 10);
        press(0, 1, 0, 10);
        checks++; if (bus.Time_in !== 24'h120033) begin errors++; $display("FAIL min_invalid_inc got %h want 120033", bus.Time_in); end
        checks++; if (bus.Field_sel !== 2'b10) begin errors++; $display("FAIL min_field_sel got %b want 10", bus.Field_sel); end
    endtask

    task automatic test_commit();
        press(1, 0, 0, 10);
        checks++; if (bus.Field_sel !== 2'b11) begin errors++; $display("FAIL sec_field_sel got %b want 11", bus.Field_sel); end
        press(0, 0, 1, 10);
        checks++; if (bus.Time_in !== 24'h120032) begin errors++; $display("FAIL sec_dec got %h want 120032", bus.Time_in); end
        press(1, 0, 0, 10);
        checks++; if (pulses !== 1) begin errors++; $display("FAIL commit_pulses got %0d want 1", pulses); end
        checks++; if (tin_pulse !== 24'h120032) begin errors++; $display("FAIL commit_time_in got %h want 120032", tin_pulse); end
        checks++; if (tin_prev !== 24'h120032 || tin_next !== 24'h120032) begin
            errors++; $display("FAIL commit_stable got prev %h next %h want 120032", tin_prev, tin_next); end
        checks++; if (bus.Field_sel !== 2'b00 || bus.Editing !== 1'b0) begin
            errors++; $display("FAIL commit_idle got sel %b editing %b want 00 0", bus.Field_sel, bus.Editing); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.Time_now = 24'h081530;
        press(1, 0, 0, 10);
        press(0, 1, 0, 2);
        checks++; if (bus.Time_in !== 24'h081530) begin errors++; $display("FAIL glitch got %h want 081530", bus.Time_in); end
        press(0, 1, 1, 10);
        checks++; if (bus.Time_in !== 24'h081530) begin errors++; $display("FAIL inc_dec_cancel got %h want 081530", bus.Time_in); end
        press(1, 1, 0, 10);
        checks++; if (bus.Field_sel !== 2'b10) begin errors++; $display("FAIL mode_inc_sel got %b want 10", bus.Field_sel); end
        checks++; if (bus.Time_in !== 24'h081530) begin errors++; $display("FAIL mode_inc_field got %h want 081530", bus.Time_in); end
    endtask

    task automatic test_reset_mid();
        int st;
        do_reset();
        bus.Time_now = 24'h111111;
        press(1, 0, 0, 10);
        press(1, 0, 0, 10);
        press(1, 0, 0, 10);
        checks++; if (bus.Field_sel !== 2'b11) begin errors++; $display("FAIL mid_setup got %b want 11", bus.Field_sel); end
        @(posedge CLK);
        #2 Reset = 1;
        #1;
        checks++; if (bus.Time_in !== 24'h0 || bus.Editing !== 1'b0 || bus.Field_sel !== 2'b00 || bus.Set_time !== 1'b0) begin
            errors++; $display("FAIL mid_reset got time %h edit %b sel %b set %b want all 0",
                               bus.Time_in, bus.Editing, bus.Field_sel, bus.Set_time); end
        @(negedge CLK);
        Reset = 0;
        m_fld = 0;
        m_sh  = '0;
        st = 0;
        repeat (20) begin
            @(negedge CLK);
            if (bus.Set_time) st++;
        end
        checks++; if (st !== 0) begin errors++; $display("FAIL mid_no_pulse got %0d pulses want 0", st); end
    endtask

    task automatic test_random();
        int r, h;
        bit b;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 5));
            h = int'($urandom_range(DEB + 3, 12));
            if (m_fld == 0) bus.Time_now = 24'($urandom);
            case (r)
                0: press(1, 0, 0, h);
                1: press(0, 1, 0, h);
                2: press(0, 0, 1, h);
                3: press(0, 1, 1, h);
                4: press(1, 1, 0, h);
                default: begin
                    b = 1'($urandom);
                    press(0, b, ~b, int'($urandom_range(1, DEB - 1)));
                end
            endcase
            checks++; if (bus.Time_in !== m_sh) begin errors++; $display("FAIL rnd_time_in n=%0d got %h want %h", n, bus.Time_in, m_sh); end
            checks++; if (bus.Field_sel !== 2'(m_fld) || bus.Editing !== (m_fld != 0)) begin
                errors++; $display("FAIL rnd_state n=%0d got sel %b edit %b want sel %0d", n, bus.Field_sel, bus.Editing, m_fld); end
            checks++; if (pulses !== exp_pulses) begin errors++; $display("FAIL rnd_pulses n=%0d got %0d want %0d", n, pulses, exp_pulses); end
        end
    endtask

    initial begin
        bus.Time_now = '0;
        test_reset();
        test_mode_entry();
        test_hours();
        test_minutes();
        test_commit();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
